// File: rtl/pipa_count_req.sv
// PIPA pending-count tracker: accumulates signed per-channel pulse counts
// and raises one round-robin increment request at a time until it is acked.
//
// Ports:
//   CLOCK, rst        sole clock, synchronous active-high reset
//   PIPSAM            sample strobe for PIPAP_/PIPAM_
//   PIPAP_, PIPAM_    active-low plus/minus pulses, one bit per channel
//   ACK               grant for the current request
//   CLRF              clears the sticky FAIL/OVF flags
//   REQ, REQCH, REQDN request pending, its channel, 0=PINC 1=MINC
//   PEND              flattened signed counts, channel i at [i*PW +: PW]
//   FAIL, OVF         sticky plus-and-minus-together / saturation flags
module pipa_count_req #(
    parameter int NCH = 3,
    parameter int PW  = 4,
    parameter int CW  = 2
) (
    input  logic              CLOCK,
    input  logic              rst,
    input  logic              PIPSAM,
    input  logic [NCH-1:0]    PIPAP_,
    input  logic [NCH-1:0]    PIPAM_,
    input  logic              ACK,
    input  logic              CLRF,
    output logic              REQ,
    output logic [CW-1:0]     REQCH,
    output logic              REQDN,
    output logic [NCH*PW-1:0] PEND,
    output logic [NCH-1:0]    FAIL,
    output logic [NCH-1:0]    OVF
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    localparam logic signed [PW+1:0] ONE   = (PW+2)'(1);
    localparam logic signed [PW+1:0] MAXV  = (PW+2)'(2**(PW-1)-1);
    localparam logic signed [PW+1:0] NMAXV = -MAXV;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_reqch;
    logic [CW-1:0]        w_reqch_nxt;
    logic                 r_reqdn;
    logic                 w_reqdn_nxt;
    logic [CW-1:0]        r_rr;
    logic [CW-1:0]        w_rr_nxt;
    logic [NCH-1:0]       r_fail;
    logic [NCH-1:0]       r_ovf;
    logic [PW-1:0]        r_pend     [NCH];
    logic [PW-1:0]        w_pend_nxt [NCH];
    logic signed [PW+1:0] w_sum      [NCH];
    logic [NCH-1:0]       w_fail_set;
    logic [NCH-1:0]       w_ovf_set;
    logic                 w_ack;
    logic                 w_found;
    logic [CW-1:0]        w_sel;
    logic [CW:0]          w_idx;

    // ACK only counts while a request is actually committed.
    assign w_ack = (r_state == ST_BUSY) && ACK;

    always_comb begin
        w_fail_set = '0;
        w_ovf_set  = '0;
        for (int i = 0; i < NCH; i++) begin
            w_sum[i] = {{2{r_pend[i][PW-1]}}, r_pend[i]};
            if (PIPSAM && !PIPAP_[i] && PIPAM_[i])
                w_sum[i] = w_sum[i] + ONE;
            if (PIPSAM && PIPAP_[i] && !PIPAM_[i])
                w_sum[i] = w_sum[i] - ONE;
            if (PIPSAM && !PIPAP_[i] && !PIPAM_[i])
                w_fail_set[i] = 1'b1;
            if (w_ack && (r_reqch == CW'(i)))
                w_sum[i] = r_reqdn ? w_sum[i] + ONE
                                   : w_sum[i] - ONE;
            // Symmetric clamp: the most-negative code is never produced.
            w_pend_nxt[i] = w_sum[i][PW-1:0];
            if (w_sum[i] > MAXV) begin
                w_pend_nxt[i] = MAXV[PW-1:0];
                w_ovf_set[i]  = 1'b1;
            end else if (w_sum[i] < NMAXV) begin
                w_pend_nxt[i] = NMAXV[PW-1:0];
                w_ovf_set[i]  = 1'b1;
            end
        end
    end

    // Round-robin search over registered counts, starting at r_rr.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            w_idx = {1'b0, r_rr} + (CW+1)'(k);
            if (w_idx >= (CW+1)'(NCH))
                w_idx = w_idx - (CW+1)'(NCH);
            if (!w_found && (r_pend[w_idx[CW-1:0]] != '0)) begin
                w_found = 1'b1;
                w_sel   = w_idx[CW-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_reqch_nxt = r_reqch;
        w_reqdn_nxt = r_reqdn;
        w_rr_nxt    = r_rr;
        unique case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_BUSY;
                    w_reqch_nxt = w_sel;
                    w_reqdn_nxt = r_pend[w_sel][PW-1];
                end
            end
            ST_BUSY: begin
                if (ACK) begin
                    w_state_nxt = ST_IDLE;
                    w_rr_nxt    = (r_reqch == CW'(NCH-1)) ? '0
                                : r_reqch + CW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_reqch <= '0;
            r_reqdn <= 1'b0;
            r_rr    <= '0;
            r_fail  <= '0;
            r_ovf   <= '0;
            for (int i = 0; i < NCH; i++)
                r_pend[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_reqch <= w_reqch_nxt;
            r_reqdn <= w_reqdn_nxt;
            r_rr    <= w_rr_nxt;
            // A set in the same cycle wins over CLRF.
            r_fail  <= (CLRF ? '0 : r_fail) | w_fail_set;
            r_ovf   <= (CLRF ? '0 : r_ovf) | w_ovf_set;
            for (int i = 0; i < NCH; i++)
                r_pend[i] <= w_pend_nxt[i];
        end
    end

    assign REQ   = (r_state == ST_BUSY);
    assign REQCH = r_reqch;
    assign REQDN = r_reqdn;
    assign FAIL  = r_fail;
    assign OVF   = r_ovf;

    for (genvar g = 0; g < NCH; g++) begin : g_pend
        assign PEND[g*PW +: PW] = r_pend[g];
    end

endmodule

// File: doc/pipa_count_req.md
PIPA_COUNT_REQ -- requirements
Module: pipa_count_req

Interface
REQ-001 Parameter NCH, default 3, number of PIPA channels (1..8).
REQ-002 Parameter PW, default 4, width of each signed pending-count register (3..8).
REQ-003 Parameter CW, default 2, channel-index width; SHALL satisfy 2^CW >= NCH.
REQ-004 CLOCK  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 PIPSAM  in  1  sample strobe; PIPA inputs counted only in cycles where PIPSAM=1.
REQ-007 PIPAP_  in  NCH  active-low plus pulses, one bit per channel.
REQ-008 PIPAM_  in  NCH  active-low minus pulses, one bit per channel.
REQ-009 ACK  in  1  counter-cycle grant for the current request.
REQ-010 CLRF  in  1  clears sticky FAIL/OVF flags.
REQ-011 REQ  out  1  increment request pending.
REQ-012 REQCH  out  CW  channel of current request.
REQ-013 REQDN  out  1  request direction: 0 = PINC, 1 = MINC.
REQ-014 PEND  out  NCH*PW  flattened two's-complement pending counts; channel i at bits [i*PW +: PW].
REQ-015 FAIL  out  NCH  sticky per-channel "plus and minus together" flag.
REQ-016 OVF  out  NCH  sticky per-channel saturation flag.

Function
REQ-017 Sample delta ds[i]: with PIPSAM=1, P_=0/M_=1 gives +1; P_=1/M_=0 gives -1; both high gives 0; with PIPSAM=0, ds=0.
REQ-018 Both P_ and M_ low with PIPSAM=1: ds[i]=0 and FAIL[i] set next edge.
REQ-019 Ack delta da[i]: when ACK=1, REQ=1 and REQCH=i, da[i] = -1 if REQDN=0, +1 if REQDN=1; otherwise 0; ACK with REQ=0 ignored.
REQ-020 PEND[i] next = clamp(PEND[i] + ds[i] + da[i]) to +/-(2^(PW-1)-1); most-negative code never produced.
REQ-021 Clamp active: OVF[i] set next edge; opposing ds/da in same cycle cancel with no OVF.
REQ-022 Sample effect visible on PEND one edge after the PIPSAM cycle (latency 1).
REQ-023 Arbiter FSM states IDLE and BUSY; REQ=1 exactly in BUSY.
REQ-024 IDLE: if any registered PEND[j] != 0, select first such j searching round-robin from pointer RR upward mod NCH; next edge load REQCH=j, REQDN=sign(PEND[j]), enter BUSY.
REQ-025 IDLE with all PEND zero: remain IDLE, REQCH/REQDN hold.
REQ-026 BUSY: REQ, REQCH, REQDN held stable until ACK=1.
REQ-027 BUSY with ACK=1: apply da, RR = REQCH+1 mod NCH, return to IDLE next edge; minimum one IDLE cycle between requests.
REQ-028 Committed request not withdrawn if PEND[REQCH] reaches zero or changes sign while BUSY; ack still applied, sign re-evaluated at next arbitration.
REQ-029 Request-to-ack has no timeout; BUSY held indefinitely.
REQ-030 CLRF=1 clears FAIL and OVF next edge; a set condition in the same cycle wins over CLRF.
REQ-031 Arbitration uses registered PEND values; a sample in the IDLE cycle affects the next arbitration, not the current one.

Reset
REQ-032 rst=1 at an edge: PEND all 0, REQ 0, REQCH 0, REQDN 0, FAIL 0, OVF 0, RR 0, state IDLE.
REQ-033 rst overrides PIPSAM, ACK and CLRF in the same cycle; reset mid-request drops REQ at that edge with no PEND update.

Verification
REQ-034 Single plus pulse ch1 with PIPSAM -> PEND1=1 next edge, REQ=1/REQCH=1/REQDN=0 one edge later; ACK -> PEND1=0, REQ=0.
REQ-035 Minus pulses ch0 and ch2 together, RR=0 -> requests granted in order ch0 then ch2, each REQDN=1, each PEND back to 0.
REQ-036 Eight plus samples ch0 with no ACK, PW=4 -> PEND0 stops at 7, OVF0=1; CLRF -> OVF0=0, PEND0 remains 7.
REQ-037 P_ and M_ both low ch1 with PIPSAM -> PEND1 unchanged, FAIL1=1, no REQ.
REQ-038 BUSY on ch0 plus with PEND0=1, minus sample ch0 and ACK in same cycle -> PEND0=-1, next request REQDN=1.
REQ-039 rst asserted while BUSY with PEND0=3 -> next edge REQ=0, PEND0=0, all flags 0.
